pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//
// Purpose:
//   Soft-start / soft-stop controller for a PWM duty value. It accepts a
//   target duty and a per-period step through a valid/ready handshake. It then
//   walks the registered duty toward the target, changing it only on the
//   period wrap, so no PWM period ever sees a partial duty.
//
// Optional feature:
//   PWM_RAMP_RETARGET_EN - when defined, a new target may be accepted while a
//   ramp is in progress. Direction is recomputed from the current duty, and
//   the abandoned target produces no done pulse. When the macro is undefined,
//   targets are only accepted in IDLE.
//
// Parameters:
//   R            duty / period-counter width; PWM period is 2**R clk cycles
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   tgt_valid    new target offered
//   tgt_ready    block can accept a target
//   tgt_duty     requested final duty (sampled on accept)
//   step         ramp increment per PWM period (sampled on accept)
//   hold         freezes ramping while high (a held wrap is skipped)
//   duty         registered duty for the downstream PWM generator
//   period_start high on the last cycle of each period (cnt == 2**R-1)
//   busy         high while ramping
//   done         one-cycle pulse when duty reaches the target
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
   parameter int R = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tgt_valid,
   output logic         tgt_ready,
   input  logic [R-1:0] tgt_duty,
   input  logic [R-1:0] step,
   input  logic         hold,
   output logic [R-1:0] duty,
   output logic         period_start,
   output logic         busy,
   output logic         done
);

`ifdef PWM_RAMP_RETARGET_EN
   localparam logic RETARGET = 1'b1;
`else
   localparam logic RETARGET = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } state_t;

   state_t       state_reg;
   logic [R-1:0] cnt_reg;
   logic [R-1:0] duty_reg;
   logic [R-1:0] tgt_reg;
   logic [R-1:0] step_reg;
   logic         done_reg;
   logic         ready_reg;

   logic         wrap;
   logic         accept;
   logic [R:0]   up_diff;
   logic [R:0]   dn_diff;
   logic [R:0]   step_ext;
   logic         up_last;
   logic         dn_last;
   logic [R-1:0] duty_up;
   logic [R-1:0] duty_dn;

   // Last cycle of the period. Duty updates land on this edge, so the new
   // value is in place from cnt == 0 onward.
   assign wrap   = (cnt_reg == {R{1'b1}});
   assign accept = tgt_valid & ready_reg;

   // Remaining distance is computed one bit wider than the duty. Comparing it
   // against the step decides whether this step would reach or pass the
   // target. In that case duty is clamped to the target, so it can never
   // overshoot or wrap around.
   assign step_ext = {1'b0, step_reg};
   assign up_diff  = {1'b0, tgt_reg}  - {1'b0, duty_reg};
   assign dn_diff  = {1'b0, duty_reg} - {1'b0, tgt_reg};
   assign up_last  = (step_reg == '0) || (up_diff <= step_ext);
   assign dn_last  = (step_reg == '0) || (dn_diff <= step_ext);

   // Only used when the step does not reach the target, so neither can
   // overflow or underflow.
   assign duty_up  = duty_reg + step_reg;
   assign duty_dn  = duty_reg - step_reg;

   // Control FSM plus the datapath registers it owns.
   // Ready is a registered output. It is updated together with the state so
   // that it is low during reset and high from the first edge after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         duty_reg  <= '0;
         tgt_reg   <= '0;
         step_reg  <= '0;
         done_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_reg + 1'b1;
         done_reg <= 1'b0;

         if (accept) begin
            // An accept only captures the request, even on a wrap edge.
            // The first step happens on the following wrap.
            tgt_reg  <= tgt_duty;
            step_reg <= step;
            if (tgt_duty > duty_reg) begin
               state_reg <= RAMP_UP;
               ready_reg <= RETARGET;
            end else if (tgt_duty < duty_reg) begin
               state_reg <= RAMP_DOWN;
               ready_reg <= RETARGET;
            end else begin
               // Already at the target: finish without touching duty.
               state_reg <= IDLE;
               done_reg  <= 1'b1;
               ready_reg <= 1'b1;
            end
         end else begin
            case (state_reg)
               IDLE: begin
                  ready_reg <= 1'b1;
               end

               RAMP_UP: begin
                  // A held wrap is skipped, not deferred to a later cycle.
                  if (wrap && !hold) begin
                     if (up_last) begin
                        duty_reg  <= tgt_reg;
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                     end else begin
                        duty_reg  <= duty_up;
                     end
                  end
               end

               RAMP_DOWN: begin
                  if (wrap && !hold) begin
                     if (dn_last) begin
                        duty_reg  <= tgt_reg;
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                     end else begin
                        duty_reg  <= duty_dn;
                     end
                  end
               end

               default: begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            endcase
         end
      end
   end

   assign tgt_ready    = ready_reg;
   assign duty         = duty_reg;
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;
   // Reset forces cnt to zero, which also forces this low immediately.
   assign period_start = wrap;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

   localparam int R = 8;

`ifdef PWM_RAMP_RETARGET_EN
   localparam logic RETARGET = 1'b1;
`else
   localparam logic RETARGET = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         tgt_valid = 1'b0;
   logic         tgt_ready;
   logic [R-1:0] tgt_duty = '0;
   logic [R-1:0] step = '0;
   logic         hold = 1'b0;
   logic [R-1:0] duty;
   logic         period_start;
   logic         busy;
   logic         done;

   pwm_ramp_ctrl #(.R(R)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tgt_valid    (tgt_valid),
      .tgt_ready    (tgt_ready),
      .tgt_duty     (tgt_duty),
      .step         (step),
      .hold         (hold),
      .duty         (duty),
      .period_start (period_start),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] cur = 8'd0;   // model of the duty the DUT should hold

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Offer a target in the middle of a period, never on the wrap edge.
   task automatic offer(input logic [7:0] t, input logic [7:0] s, input logic exp_ready);
      @(negedge clk);
      if (period_start) @(negedge clk);
      chk("tgt_ready_before_offer", 32'(tgt_ready), 32'(exp_ready));
      tgt_duty  = t;
      step      = s;
      tgt_valid = 1'b1;
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
   endtask

   // Advance until period_start is seen at a post-edge sample. Duty must stay
   // constant and done low in between. Optionally the full gap is checked.
   task automatic wait_wrap(input logic check_gap);
      int   n  = 0;
      logic ok = 1'b1;
      while (!period_start && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (!period_start && (duty !== cur || done !== 1'b0)) ok = 1'b0;
      end
      chk("wrap_seen", 32'(period_start), 32'd1);
      chk("duty_stable_mid_period", 32'(ok), 32'd1);
      if (check_gap) chk("period_gap", 32'(n), 32'd255);
   endtask

   // Reset mid-period, check immediate effect, release and time the first wrap.
   task automatic reset_seq();
      int   n  = 0;
      logic ok = 1'b1;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_duty", 32'(duty), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_period_start", 32'(period_start), 32'd0);
      chk("rst_tgt_ready", 32'(tgt_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cur = 8'd0;
      @(posedge clk);
      #1;
      n = 1;
      chk("ready_after_release", 32'(tgt_ready), 32'd1);
      while (!period_start && n < 400) begin
         if (done !== 1'b0 || duty !== 8'd0 || busy !== 1'b0) ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      chk("quiet_after_release", 32'(ok), 32'd1);
      chk("first_period_start_edges", 32'(n), 32'd255);
      @(posedge clk);
      #1;   // past the first wrap, cnt == 0
   endtask

   typedef struct {
      logic [7:0]      tgt;
      logic [7:0]      stp;
      int              hold_wrap;   // wrap index with hold high, -1 for none
      int              n;           // wraps expected; 0 means tgt == duty
      logic [4:0][7:0] exp;         // duty after each wrap
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input logic [7:0] t, input logic [7:0] s, input int hw, input int n,
                               input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3, input logic [7:0] e4);
      vec_t v;
      v.tgt = t; v.stp = s; v.hold_wrap = hw; v.n = n;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
      return v;
   endfunction

   initial begin
      vecs[0] = mk(8'd64,  8'd16,  -1, 4, 8'd16,  8'd32,  8'd48, 8'd64, 8'd0);
      vecs[1] = mk(8'd0,   8'd20,  -1, 4, 8'd44,  8'd24,  8'd4,  8'd0,  8'd0);
      vecs[2] = mk(8'd192, 8'd0,   -1, 1, 8'd192, 8'd0,   8'd0,  8'd0,  8'd0);
      vecs[3] = mk(8'd192, 8'd5,   -1, 0, 8'd0,   8'd0,   8'd0,  8'd0,  8'd0);
      vecs[4] = mk(8'd0,   8'd0,   -1, 1, 8'd0,   8'd0,   8'd0,  8'd0,  8'd0);
      vecs[5] = mk(8'd64,  8'd16,   1, 5, 8'd16,  8'd16,  8'd32, 8'd48, 8'd64);
      vecs[6] = mk(8'd255, 8'd100, -1, 2, 8'd164, 8'd255, 8'd0,  8'd0,  8'd0);
      vecs[7] = mk(8'd250, 8'd3,   -1, 2, 8'd252, 8'd250, 8'd0,  8'd0,  8'd0);
      vecs[8] = mk(8'd0,   8'd255, -1, 1, 8'd0,   8'd0,   8'd0,  8'd0,  8'd0);

      reset_seq();

      // Table-driven ramps.
      for (int i = 0; i < 9; i++) begin
         offer(vecs[i].tgt, vecs[i].stp, 1'b1);
         if (vecs[i].n == 0) begin
            chk("eq_done_pulse", 32'(done), 32'd1);
            chk("eq_busy", 32'(busy), 32'd0);
            chk("eq_duty", 32'(duty), 32'(cur));
            @(posedge clk);
            #1;
            chk("eq_done_clear", 32'(done), 32'd0);
         end else begin
            chk("accept_busy", 32'(busy), 32'd1);
            chk("accept_done", 32'(done), 32'd0);
            for (int k = 0; k < vecs[i].n; k++) begin
               wait_wrap(k > 0);
               if (k == vecs[i].hold_wrap) hold = 1'b1;
               @(posedge clk);
               #1;
               hold = 1'b0;
               cur = vecs[i].exp[k];
               $display("vec %0d wrap %0d: duty=%0d exp=%0d done=%0d busy=%0d",
                        i, k, duty, cur, done, busy);
               chk("wrap_duty", 32'(duty), 32'(cur));
               chk("wrap_done", 32'(done), 32'(k == vecs[i].n - 1));
               chk("wrap_busy", 32'(busy), 32'(k != vecs[i].n - 1));
            end
            @(posedge clk);
            #1;
            chk("done_single_cycle", 32'(done), 32'd0);
         end
      end

      // Accept on the wrap edge: capture only, step on the following wrap.
      wait_wrap(1'b0);
      @(negedge clk);
      chk("wrap_accept_ready", 32'(tgt_ready), 32'd1);
      tgt_duty = 8'd32; step = 8'd32; tgt_valid = 1'b1;
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
      chk("wrap_accept_no_step", 32'(duty), 32'(cur));
      chk("wrap_accept_busy", 32'(busy), 32'd1);
      wait_wrap(1'b1);
      @(posedge clk);
      #1;
      cur = 8'd32;
      $display("wrap-accept: duty=%0d exp=32 done=%0d", duty, done);
      chk("wrap_accept_duty", 32'(duty), 32'd32);
      chk("wrap_accept_done", 32'(done), 32'd1);

      // Retarget attempt at duty 32 while ramping to 128.
      offer(8'd128, 8'd16, 1'b1);
      offer(8'd0, 8'd16, RETARGET);
      chk("retarget_no_done", 32'(done), 32'd0);
      begin
         logic [7:0] rexp [6];
         int rn;
         if (RETARGET) begin
            rexp[0] = 8'd16; rexp[1] = 8'd0; rn = 2;
         end else begin
            rexp[0] = 8'd48; rexp[1] = 8'd64; rexp[2] = 8'd80;
            rexp[3] = 8'd96; rexp[4] = 8'd112; rexp[5] = 8'd128; rn = 6;
         end
         for (int k = 0; k < rn; k++) begin
            wait_wrap(k > 0);
            @(posedge clk);
            #1;
            cur = rexp[k];
            $display("retarget wrap %0d: duty=%0d exp=%0d done=%0d", k, duty, cur, done);
            chk("retarget_duty", 32'(duty), 32'(cur));
            chk("retarget_done", 32'(done), 32'(k == rn - 1));
         end
         @(posedge clk);
         #1;
         chk("retarget_done_clear", 32'(done), 32'd0);
      end

      // Reset mid-ramp abandons the ramp with no done pulse.
      offer(8'd200, 8'd10, 1'b1);
      wait_wrap(1'b0);
      @(posedge clk);
      #1;
      cur = cur + 8'd10;
      chk("pre_reset_step", 32'(duty), 32'(cur));
      repeat (37) @(posedge clk);
      reset_seq();
      chk("post_reset_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
